// File: rtl/uart_int_decoder_pkg.sv
// rtl/uart_int_decoder_pkg.sv - ASCII constants, byte classes, FSM states and int32 limits
package uart_int_decoder_pkg;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_9     = 8'h39;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_TAB   = 8'h09;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  // Magnitudes on the 34-bit accumulator; negative tokens may reach one more.
  localparam logic [33:0] INT32_MAX_MAG = 34'd2147483647;
  localparam logic [33:0] INT32_MIN_MAG = 34'd2147483648;

  typedef enum logic [1:0] {
    CLS_DIGIT,
    CLS_MINUS,
    CLS_TERM,
    CLS_OTHER
  } byte_class_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SIGN,
    ST_DIGITS,
    ST_SKIP
  } dec_state_t;

endpackage

// File: rtl/ascii_classify.sv
// rtl/ascii_classify.sv - combinational byte class and decimal digit value map
module ascii_classify
  import uart_int_decoder_pkg::*;
(
  input  logic [7:0]  data,
  output byte_class_t cls,
  output logic [3:0]  digit
);

  always_comb begin
    cls   = CLS_OTHER;
    digit = 4'd0;
    if (data >= ASC_0 && data <= ASC_9) begin
      cls   = CLS_DIGIT;
      digit = data[3:0];
    end else if (data == ASC_MINUS) begin
      cls = CLS_MINUS;
    end else if (data == ASC_SP || data == ASC_TAB || data == ASC_CR || data == ASC_LF) begin
      cls = CLS_TERM;
    end
  end

endmodule

// File: rtl/uart_int_decoder.sv
// rtl/uart_int_decoder.sv - turns whitespace-delimited ASCII decimal tokens into signed 32-bit values
module uart_int_decoder
  import uart_int_decoder_pkg::*;
#(
  parameter int MAX_DIGITS     = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        decoder_valid,
  output logic [31:0] decoder_data,
  output logic        format_error,
  output logic        busy
);

  localparam int          CW        = $clog2(MAX_DIGITS + 1);
  localparam bit          TMR_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMR_LAST  = TMR_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

  dec_state_t    state_q, state_d;
  logic [33:0]   acc_q, acc_d;
  logic          neg_q, neg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   tmr_q, tmr_d;
  logic          valid_d, err_d;
  logic [31:0]   data_d;

  byte_class_t   cls;
  logic [3:0]    digit;
  logic [37:0]   mul;
  logic [37:0]   lim;
  logic          emit, clear;

  ascii_classify u_classify (
    .data  (rx_data),
    .cls   (cls),
    .digit (digit)
  );

  // Widened so the range check never sees a wrapped product.
  assign mul = ({4'd0, acc_q} << 3) + ({4'd0, acc_q} << 1) + 38'(digit);
  assign lim = neg_q ? {4'd0, INT32_MIN_MAG} : {4'd0, INT32_MAX_MAG};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    tmr_d   = 32'd0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    data_d  = decoder_data;
    emit    = 1'b0;
    clear   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          case (cls)
            CLS_MINUS: begin
              neg_d   = 1'b1;
              state_d = ST_SIGN;
            end
            CLS_DIGIT: begin
              acc_d   = 34'(digit);
              cnt_d   = CW'(1);
              state_d = ST_DIGITS;
            end
            CLS_OTHER: begin
              err_d   = 1'b1;
              state_d = ST_SKIP;
            end
            default: ;
          endcase
        end
      end

      ST_SIGN: begin
        if (rx_valid) begin
          case (cls)
            CLS_DIGIT: begin
              acc_d   = 34'(digit);
              cnt_d   = CW'(1);
              state_d = ST_DIGITS;
            end
            CLS_TERM: begin
              err_d   = 1'b1;
              clear   = 1'b1;
              state_d = ST_IDLE;
            end
            default: begin
              err_d   = 1'b1;
              clear   = 1'b1;
              state_d = ST_SKIP;
            end
          endcase
        end
      end

      ST_DIGITS: begin
        if (rx_valid) begin
          case (cls)
            CLS_DIGIT: begin
              if (cnt_q >= CNT_MAX || mul > lim) begin
                err_d   = 1'b1;
                clear   = 1'b1;
                state_d = ST_SKIP;
              end else begin
                acc_d = mul[33:0];
                cnt_d = cnt_q + CW'(1);
              end
            end
            CLS_TERM: emit = 1'b1;
            default: begin
              err_d   = 1'b1;
              clear   = 1'b1;
              state_d = ST_SKIP;
            end
          endcase
        end else if (TMR_EN) begin
          if (tmr_q == TMR_LAST) emit = 1'b1;
          else                   tmr_d = tmr_q + 32'd1;
        end
      end

      ST_SKIP: begin
        if (rx_valid && cls == CLS_TERM) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      valid_d = 1'b1;
      data_d  = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
      clear   = 1'b1;
      state_d = ST_IDLE;
    end
    if (clear) begin
      acc_d = 34'd0;
      neg_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      acc_q         <= 34'd0;
      neg_q         <= 1'b0;
      cnt_q         <= '0;
      tmr_q         <= 32'd0;
      decoder_valid <= 1'b0;
      format_error  <= 1'b0;
      decoder_data  <= 32'd0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      neg_q         <= neg_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      decoder_valid <= valid_d;
      format_error  <= err_d;
      decoder_data  <= data_d;
    end
  end

  assign busy = (state_q == ST_SIGN) || (state_q == ST_DIGITS);

endmodule

// File: tb/tb_uart_int_decoder.sv
// tb/tb_uart_int_decoder.sv - directed vector table plus timeout and reset sequences
module tb_uart_int_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        decoder_valid;
  logic [31:0] decoder_data;
  logic        format_error;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  uart_int_decoder #(
    .MAX_DIGITS     (10),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .decoder_valid (decoder_valid),
    .decoder_data  (decoder_data),
    .format_error  (format_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic        v;
    logic        e;
    logic [31:0] d;
    logic        bsy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] b, input logic v, input logic e,
                     input logic [31:0] d, input logic bsy);
    vec_t x;
    x.b = b; x.v = v; x.e = e; x.d = d; x.bsy = bsy;
    vecs.push_back(x);
  endtask

  // Bytes that produce no pulse, with decoder_data holding d.
  task automatic add_quiet(input string s, input logic [31:0] d, input logic bsy);
    for (int i = 0; i < s.len(); i++) add(s[i], 1'b0, 1'b0, d, bsy);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // "42\r"
    add_quiet("42", 32'd0, 1'b1);
    add(8'h0D, 1'b1, 1'b0, 32'd42, 1'b0);
    // "-7 12\n"
    add_quiet("-7", 32'd42, 1'b1);
    add(" ", 1'b1, 1'b0, 32'hFFFF_FFF9, 1'b0);
    add_quiet("12", 32'hFFFF_FFF9, 1'b1);
    add(8'h0A, 1'b1, 1'b0, 32'h0000_000C, 1'b0);
    // "2147483648 " overflows on the last digit
    add_quiet("214748364", 32'h0C, 1'b1);
    add("8", 1'b0, 1'b1, 32'h0C, 1'b0);
    add(" ", 1'b0, 1'b0, 32'h0C, 1'b0);
    // "-2147483648 "
    add_quiet("-2147483648", 32'h0C, 1'b1);
    add(" ", 1'b1, 1'b0, 32'h8000_0000, 1'b0);
    // "2147483647 "
    add_quiet("2147483647", 32'h8000_0000, 1'b1);
    add(" ", 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b0);
    // "1a3 5 "
    add("1", 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1);
    add("a", 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0);
    add_quiet("3 ", 32'h7FFF_FFFF, 1'b0);
    add("5", 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1);
    add(" ", 1'b1, 1'b0, 32'd5, 1'b0);
    // "- " and "   "
    add("-", 1'b0, 1'b0, 32'd5, 1'b1);
    add(" ", 1'b0, 1'b1, 32'd5, 1'b0);
    add_quiet("   ", 32'd5, 1'b0);
    // eleven digits exceeds MAX_DIGITS
    add_quiet("1234567890", 32'd5, 1'b1);
    add("1", 1'b0, 1'b1, 32'd5, 1'b0);
    add(" ", 1'b0, 1'b0, 32'd5, 1'b0);
    // "--" rejected once, then "-0\t" gives zero
    add("-", 1'b0, 1'b0, 32'd5, 1'b1);
    add("-", 1'b0, 1'b1, 32'd5, 1'b0);
    add(8'h09, 1'b0, 1'b0, 32'd5, 1'b0);
    add_quiet("-0", 32'd5, 1'b1);
    add(8'h09, 1'b1, 1'b0, 32'd0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(decoder_valid), 32'd0);
    chk("rst_data", decoder_data, 32'd0);
    chk("rst_error", 32'(format_error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      strobe(vecs[i].b);
      chk($sformatf("v%0d_valid", i), 32'(decoder_valid), 32'(vecs[i].v));
      chk($sformatf("v%0d_error", i), 32'(format_error), 32'(vecs[i].e));
      chk($sformatf("v%0d_data", i), decoder_data, vecs[i].d);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pulse_valid", i), 32'(decoder_valid), 32'd0);
      chk($sformatf("v%0d_pulse_error", i), 32'(format_error), 32'd0);
    end

    // Timeout: valid 16 edges after the strobe's sampling edge
    strobe("9");
    for (int k = 1; k < 16; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("tmo_wait%0d", k), 32'(decoder_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("tmo_valid", 32'(decoder_valid), 32'd1);
    chk("tmo_data", decoder_data, 32'd9);
    chk("tmo_busy", 32'(busy), 32'd0);

    // Byte arriving on the expiry edge suppresses the timeout
    strobe("9");
    repeat (15) @(posedge clk);
    strobe("1");
    chk("coinc_valid", 32'(decoder_valid), 32'd0);
    chk("coinc_error", 32'(format_error), 32'd0);
    chk("coinc_busy", 32'(busy), 32'd1);
    strobe(8'h0A);
    chk("coinc_emit_valid", 32'(decoder_valid), 32'd1);
    chk("coinc_emit_data", decoder_data, 32'd91);

    // Reset mid-token discards the partial value
    strobe("1");
    strobe("2");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", decoder_data, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(decoder_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst_quiet%0d", k), 32'({decoder_valid, format_error}), 32'd0);
    end
    strobe("3");
    chk("post_rst_busy", 32'(busy), 32'd1);
    strobe(8'h0A);
    chk("post_rst_valid", 32'(decoder_valid), 32'd1);
    chk("post_rst_data", decoder_data, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
